// File: rtl/line_memory_responder.sv
// Line-granular backing store answering READ/WRITE after a fixed latency, plus a
// back-invalidate (evict) channel. Define MEM_STATS_EN to add saturating event counters.
module line_memory_responder #(
  parameter int unsigned ADDRBITS      = 32,
  parameter int unsigned WORDBITS      = 32,
  parameter int unsigned LINEITEMS     = 64,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned READ_LAT      = 4,
  parameter int unsigned WRITE_LAT     = 2,
  parameter int unsigned EVICT_TIMEOUT = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic                          request_i,
  input  logic [1:0]                    operation_i,
  input  logic [ADDRBITS-1:0]           addr_i,
  input  logic [LINEITEMS*WORDBITS-1:0] wdata_i,
  output logic [LINEITEMS*WORDBITS-1:0] rdata_o,
  output logic                          valid_o,
  output logic                          evict_o,
  output logic [ADDRBITS-1:0]           evict_addr_o,
  input  logic                          inval_req_i,
  input  logic [ADDRBITS-1:0]           inval_addr_i,
  output logic                          busy_o
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]                   stat_reads_o,
  output logic [31:0]                   stat_writes_o,
  output logic [31:0]                   stat_evicts_o
`endif
);

  localparam int unsigned LINEW = LINEITEMS * WORDBITS;
  localparam int unsigned OFF   = $clog2(LINEW / 8);
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam int unsigned CNTW  = 16;
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [ADDRBITS-1:0] OffMask = ADDRBITS'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {StIdle, StBusy, StRespond, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                is_write_q, is_write_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [LINEW-1:0]    wdata_q, wdata_d;
  logic [LINEW-1:0]    rdata_q, rdata_d;
  logic                evict_q, evict_d;
  logic [ADDRBITS-1:0] evict_addr_q, evict_addr_d;
  logic [CNTW-1:0]     tmo_q, tmo_d;
  logic [LINEW-1:0]    mem_q [DEPTH];

  logic accept, busy_done, respond, evict_clear;
  logic unused_addr;

  assign unused_addr = ^{addr_i[ADDRBITS-1:OFF+IDXW], addr_i[OFF-1:0]};
  assign accept    = (state_q == StIdle) && request_i &&
                     ((operation_i == OpRead) || (operation_i == OpWrite));
  assign busy_done = (state_q == StBusy) && (cnt_q == '0);
  assign respond   = (state_q == StRespond);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StBusy;
      StBusy:    if (cnt_q == '0) state_d = StRespond;
      StRespond: state_d = request_i ? StDrain : StIdle;
      StDrain:   if (!request_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_o = (state_q == StRespond);
    busy_o  = (state_q != StIdle);
  end

  always_comb begin
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    if (accept) begin
      is_write_d = (operation_i == OpWrite);
      idx_d      = addr_i[OFF+IDXW-1:OFF];
      wdata_d    = wdata_i;
      cnt_d      = (operation_i == OpWrite) ? CNTW'(WRITE_LAT - 1) : CNTW'(READ_LAT - 1);
    end else if ((state_q == StBusy) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (busy_done && !is_write_q) rdata_d = mem_q[idx_q];
  end

  // A READ completion means the cache has resumed; a WRITE only clears a matching evict.
  always_comb begin
    evict_clear = evict_q &&
                  ((respond && (!is_write_q || (evict_addr_q[OFF+IDXW-1:OFF] == idx_q))) ||
                   (tmo_q <= CNTW'(1)));
    evict_d      = evict_q;
    evict_addr_d = evict_addr_q;
    tmo_d        = tmo_q;
    if (evict_q && (tmo_q != '0)) tmo_d = tmo_q - 1'b1;
    if (evict_clear) evict_d = 1'b0;
    if (inval_req_i && (!evict_q || evict_clear)) begin
      evict_d      = 1'b1;
      evict_addr_d = inval_addr_i & ~OffMask;
      tmo_d        = CNTW'(EVICT_TIMEOUT);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      evict_q      <= 1'b0;
      evict_addr_q <= '0;
      tmo_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      evict_q      <= evict_d;
      evict_addr_q <= evict_addr_d;
      tmo_q        <= tmo_d;
    end
  end

  // Storage is never reset; state_q is IDLE during reset so no write can slip through.
  always_ff @(posedge clock_i) begin
    if (busy_done && is_write_q) mem_q[idx_q] <= wdata_q;
  end

  assign rdata_o      = rdata_q;
  assign evict_o      = evict_q;
  assign evict_addr_o = evict_addr_q;

`ifdef MEM_STATS_EN
  logic [31:0] stat_reads_q, stat_writes_q, stat_evicts_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_evicts_q <= '0;
    end else begin
      if (respond && !is_write_q && (stat_reads_q != '1)) stat_reads_q <= stat_reads_q + 1'b1;
      if (respond && is_write_q && (stat_writes_q != '1)) stat_writes_q <= stat_writes_q + 1'b1;
      if (!evict_q && evict_d && (stat_evicts_q != '1)) stat_evicts_q <= stat_evicts_q + 1'b1;
    end
  end

  assign stat_reads_o  = stat_reads_q;
  assign stat_writes_o = stat_writes_q;
  assign stat_evicts_o = stat_evicts_q;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed and randomized checks of line_memory_responder against a line-array model.
module tb_line_memory_responder;
  localparam int unsigned LINEW = 64 * 32;
  localparam int unsigned DEPTH = 1024;
  localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             request = 1'b0;
  logic [1:0]       operation = NOP;
  logic [31:0]      addr = '0;
  logic [LINEW-1:0] wdata = '0;
  logic [LINEW-1:0] rdata;
  logic             valid, evict, busy;
  logic [31:0]      evict_addr;
  logic             inval_req = 1'b0;
  logic [31:0]      inval_addr = '0;

  int n_vec = 0;
  int n_fail = 0;
  logic [LINEW-1:0] ref_mem [DEPTH];
  logic [LINEW-1:0] last_rd;

  line_memory_responder dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .request_i    (request),
    .operation_i  (operation),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .valid_o      (valid),
    .evict_o      (evict),
    .evict_addr_o (evict_addr),
    .inval_req_i  (inval_req),
    .inval_addr_i (inval_addr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LINEW-1:0] obs,
                          input logic [LINEW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed low64 %h expected low64 %h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [LINEW-1:0] rand_line();
    logic [LINEW-1:0] l;
    for (int i = 0; i < LINEW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic preload(input int idx, input logic [LINEW-1:0] v);
    dut.mem_q[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, return rdata seen at valid; optionally pulse inval_req in the valid cycle.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [LINEW-1:0] wd,
                        input int exp_lat, input bit inv, input logic [31:0] ia,
                        output logic [LINEW-1:0] rd, output logic ev_at_valid);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    request = 1'b1;
    operation = op;
    addr = a;
    wdata = wd;
    while (!seen && n < 40) begin
      cyc();
      n++;
      if (valid) seen = 1;
    end
    rd = rdata;
    ev_at_valid = evict;
    chk("latency", seen ? 64'(n) : 64'hFFFF_FFFF, 64'(exp_lat));
    request = 1'b0;
    operation = NOP;
    inval_req = inv;
    inval_addr = ia;
    cyc();
    inval_req = 1'b0;
    chk("valid_one_cycle", 64'(valid), 64'd0);
    chk("busy_after_drop", 64'(busy), 64'd0);
  endtask

  task automatic pulse_inval(input logic [31:0] ia);
    inval_req = 1'b1;
    inval_addr = ia;
    cyc();
    inval_req = 1'b0;
  endtask

  initial begin
    logic [LINEW-1:0] pat_a, pat_b, rd, old7;
    logic ev;
    int k, extra, bz;
    logic [31:0] held_ea;
    bit seen;

    last_rd = '0;
    // Reset values
    #2;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_evict", 64'(evict), 64'd0);
    chk("rst_evict_addr", 64'(evict_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_line("rst_rdata", rdata, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // NOP request is ignored
    request = 1'b1;
    operation = NOP;
    bz = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bz += int'(busy) + int'(valid);
    end
    request = 1'b0;
    chk("nop_ignored", 64'(bz), 64'd0);

    // Read preloaded line 5
    pat_a = rand_line();
    preload(5, pat_a);
    do_req(RD, 32'(5) << 8, '0, 5, 0, '0, rd, ev);
    chk_line("read_line5_A", rd, pat_a);
    last_rd = pat_a;

    // Write then read line 5; rdata retained through the WRITE
    pat_b = rand_line();
    do_req(WR, 32'(5) << 8, pat_b, 3, 0, '0, rd, ev);
    ref_mem[5] = pat_b;
    chk_line("write_rdata_retained", rd, last_rd);
    do_req(RD, (32'(5) << 8) | 32'h3c, '0, 5, 0, '0, rd, ev);
    chk_line("read_after_write_B", rd, pat_b);

    // Request held after valid: single pulse, DRAIN until request drops
    request = 1'b1;
    operation = RD;
    addr = 32'(5) << 8;
    k = 0;
    seen = 0;
    while (!seen && k < 40) begin
      cyc();
      k++;
      if (valid) seen = 1;
    end
    chk("drain_latency", 64'(k), 64'd5);
    extra = 0;
    bz = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      extra += int'(valid);
      bz += int'(busy);
    end
    chk("drain_no_second_valid", 64'(extra), 64'd0);
    chk("drain_busy_held", 64'(bz), 64'd10);
    request = 1'b0;
    operation = NOP;
    cyc();
    chk("drain_exit_idle", 64'(busy), 64'd0);

    // Evict: unrelated write keeps it, matching write clears it after valid
    pulse_inval(32'h1240);
    chk("evict_armed", 64'(evict), 64'd1);
    chk("evict_addr_aligned", 64'(evict_addr), 64'h1200);
    pat_a = rand_line();
    do_req(WR, 32'h3000, pat_a, 3, 0, '0, rd, ev);
    ref_mem[32'h30] = pat_a;
    chk("unrelated_write_keeps_evict", 64'(evict), 64'd1);
    pat_b = rand_line();
    do_req(WR, 32'h1200, pat_b, 3, 0, '0, rd, ev);
    ref_mem[32'h12] = pat_b;
    chk("evict_at_matching_valid", 64'(ev), 64'd1);
    chk("evict_cleared_after_write", 64'(evict), 64'd0);
    pulse_inval(32'h1240);
    do_req(RD, 32'h3000, '0, 5, 0, '0, rd, ev);
    chk_line("read_line30", rd, ref_mem[32'h30]);
    last_rd = rd;
    chk("evict_cleared_by_read", 64'(evict), 64'd0);

    // Evict timeout, second inval during hold dropped
    inval_req = 1'b1;
    inval_addr = 32'h5540;
    k = 0;
    held_ea = '0;
    do begin
      cyc();
      inval_req = 1'b0;
      if (evict) k++;
      if (k == 5) begin
        inval_req = 1'b1;
        inval_addr = 32'h7700;
      end
      if (k == 10) held_ea = evict_addr;
    end while (evict && k < 40);
    chk("evict_timeout_cycles", 64'(k), 64'd16);
    chk("evict_addr_unchanged", 64'(held_ea), 64'h5500);

    // Inval in the RESPOND cycle of a matching WRITE arms a new evict
    pulse_inval(32'h2200);
    pat_a = rand_line();
    do_req(WR, 32'h2200, pat_a, 3, 1, 32'h4480, rd, ev);
    ref_mem[32'h22] = pat_a;
    chk("rearm_evict", 64'(evict), 64'd1);
    chk("rearm_evict_addr", 64'(evict_addr), 64'h4400);
    do_req(RD, 32'h2200, '0, 5, 0, '0, rd, ev);
    chk_line("read_line22", rd, pat_a);
    last_rd = rd;
    chk("rearm_cleared_by_read", 64'(evict), 64'd0);

    // Randomized traffic with aliasing and offset bits
    for (int j = 0; j < 8; j++) preload(j * 37 + 1, rand_line());
    for (int t = 0; t < 30; t++) begin
      int idx;
      logic [31:0] a;
      logic [LINEW-1:0] wd;
      idx = $urandom_range(0, 7) * 37 + 1;
      a = ($urandom & 32'hFFFC_0000) | (32'(idx) << 8) | ($urandom & 32'hFF);
      if ($urandom_range(0, 1) == 1) begin
        wd = rand_line();
        do_req(WR, a, wd, 3, 0, '0, rd, ev);
        chk_line("rand_write_retain", rd, last_rd);
        ref_mem[idx] = wd;
      end else begin
        do_req(RD, a, '0, 5, 0, '0, rd, ev);
        chk_line("rand_read", rd, ref_mem[idx]);
        last_rd = ref_mem[idx];
      end
    end

    // Reset during BUSY of a WRITE to line 7 aborts it
    old7 = rand_line();
    preload(7, old7);
    pulse_inval(32'h0900);
    request = 1'b1;
    operation = WR;
    addr = 32'(7) << 8;
    wdata = rand_line();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_evict", 64'(evict), 64'd0);
    chk("midrst_evict_addr", 64'(evict_addr), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk_line("midrst_rdata", rdata, '0);
    request = 1'b0;
    operation = NOP;
    cyc();
    cyc();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (valid) seen = 1;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    do_req(RD, 32'(7) << 8, '0, 5, 0, '0, rd, ev);
    chk_line("midrst_line7_old", rd, old7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
